// File: rtl/bram_lsu_if.sv
// Request/response and RAM port A bundle shared by the LSU and its environment.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the request; response and RAM side have none.
// Ports: slave = LSU view (request in, response and RAM commands out, RAM read data in);
//        master = CPU/RAM view (the mirror image).
interface bram_lsu_if #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [1:0]                  req_size;
  logic                        req_unsigned;
  logic [ADDRESS_BITWIDTH+1:0] req_address;
  logic [DATA_BITWIDTH-1:0]    req_data;
  logic                        rsp_valid;
  logic [DATA_BITWIDTH-1:0]    rsp_data;
  logic [ADDRESS_BITWIDTH-1:0] ram_address;
  logic [3:0]                  ram_write_enable;
  logic [DATA_BITWIDTH-1:0]    ram_data_out;
  logic [DATA_BITWIDTH-1:0]    ram_data_in;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_data,
    output req_ready, rsp_valid, rsp_data,
    output ram_address, ram_write_enable, ram_data_out,
    input  ram_data_in
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_data,
    input  req_ready, rsp_valid, rsp_data,
    input  ram_address, ram_write_enable, ram_data_out,
    output ram_data_in
  );
endinterface

// File: rtl/bram_lsu.sv
// Byte/half/word load-store unit in front of port A of a byte-enabled block RAM.
// Latency: rsp_valid 2 cycles after accept, 3 when the access spans two RAM words.
// Backpressure: req_ready only in IDLE (one request in flight); no response backpressure.
// Ports: clk, rst_n (async, active-low); bus (bram_lsu_if.slave) carries the request
//        handshake, the one-cycle response pulse and the RAM port A address/enables/data.
// Option: define BRAM_LSU_MISALIGNED_EN to split word-crossing accesses into two RAM
//         cycles; otherwise offsets are forced to natural alignment and nothing splits.
module bram_lsu #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  bram_lsu_if.slave  bus
);

  localparam int AW = ADDRESS_BITWIDTH;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t                   state_q;
  logic                     wr_q;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic [1:0]               off_q;
  logic [AW-1:0]            word_q;
  logic                     split_q;
  logic [31:0]              hi_dat_q;
  logic [3:0]               hi_we_q;
  logic [31:0]              low_q;
  logic [AW-1:0]            ram_address_q;
  logic [3:0]               ram_we_q;
  logic [DATA_BITWIDTH-1:0] ram_dout_q;

  // Request decode, evaluated on the live request so the FIRST-cycle RAM
  // command can be registered at the accept edge.
  logic [1:0]  off_d;
  logic [3:0]  nmask_d;
  logic [7:0]  lane_mask_d;
  logic [31:0] byte_mask_d;
  logic [63:0] st_dat_d;
  logic        split_d;
  logic        accept;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    case (bus.req_size)
      2'b00:   nmask_d = 4'b0001;
      2'b01:   nmask_d = 4'b0011;
      default: nmask_d = 4'b1111;
    endcase
`ifdef BRAM_LSU_MISALIGNED_EN
    off_d = bus.req_address[1:0];
`else
    off_d = bus.req_address[1:0];
    if (bus.req_size == 2'b01) begin
      off_d[0] = 1'b0;
    end else if (bus.req_size[1]) begin
      off_d = 2'b00;
    end
`endif
    // Lanes 3:0 belong to the addressed word, 7:4 spill into the next one.
    lane_mask_d = {4'b0000, nmask_d} << off_d;
    byte_mask_d = {{8{nmask_d[3]}}, {8{nmask_d[2]}}, {8{nmask_d[1]}}, {8{nmask_d[0]}}};
    st_dat_d    = {32'd0, bus.req_data & byte_mask_d} << {off_d, 3'b000};
`ifdef BRAM_LSU_MISALIGNED_EN
    split_d = |lane_mask_d[7:4];
`else
    split_d = 1'b0;
`endif
  end

  // Load reassembly: the upper word is whatever the RAM returns in DONE; the
  // lower word is the captured FIRST word for a split access. Only the low
  // 24 bits of the upper word can ever land in the result.
  logic [31:0] lo_word;
  logic [55:0] ld_cat;
  logic [31:0] ld_w;
  logic [31:0] ld_ext;

  always_comb begin
    lo_word = split_q ? low_q : bus.ram_data_in;
    ld_cat  = {bus.ram_data_in[23:0], lo_word};
    case (off_q)
      2'd0:    ld_w = ld_cat[31:0];
      2'd1:    ld_w = ld_cat[39:8];
      2'd2:    ld_w = ld_cat[47:16];
      default: ld_w = ld_cat[55:24];
    endcase
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_w[7:0]}  : {{24{ld_w[7]}}, ld_w[7:0]};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_w[15:0]} : {{16{ld_w[15]}}, ld_w[15:0]};
      default: ld_ext = ld_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      word_q        <= '0;
      split_q       <= 1'b0;
      hi_dat_q      <= 32'd0;
      hi_we_q       <= 4'b0000;
      low_q         <= 32'd0;
      ram_address_q <= '0;
      ram_we_q      <= 4'b0000;
      ram_dout_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wr_q          <= bus.req_write;
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            off_q         <= off_d;
            word_q        <= bus.req_address[AW+1:2];
            split_q       <= split_d;
            hi_dat_q      <= st_dat_d[63:32];
            hi_we_q       <= bus.req_write ? lane_mask_d[7:4] : 4'b0000;
            ram_address_q <= bus.req_address[AW+1:2];
            ram_we_q      <= bus.req_write ? lane_mask_d[3:0] : 4'b0000;
            ram_dout_q    <= st_dat_d[31:0];
            state_q       <= FIRST;
          end
        end
        FIRST: begin
          if (split_q) begin
            ram_address_q <= word_q + 1'b1;  // wraps at the top of the RAM
            ram_we_q      <= hi_we_q;
            ram_dout_q    <= hi_dat_q;
            state_q       <= SECOND;
          end else begin
            ram_we_q <= 4'b0000;
            state_q  <= DONE;
          end
        end
        SECOND: begin
          low_q    <= bus.ram_data_in;  // read data of the FIRST word
          ram_we_q <= 4'b0000;
          state_q  <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.rsp_valid        = (state_q == DONE);
  assign bus.rsp_data         = (state_q == DONE && !wr_q) ? ld_ext : 32'd0;
  assign bus.ram_address      = ram_address_q;
  assign bus.ram_write_enable = ram_we_q;
  assign bus.ram_data_out     = ram_dout_q;

endmodule

// File: tb/tb_bram_lsu.sv
// Directed bench for bram_lsu with a write-first byte-enabled RAM model.
// Latency: expectations are cycle-exact (accept edge T, checks at T+1..T+3).
// Backpressure: none exercised beyond req_ready being low while busy.
module tb_bram_lsu;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  bram_lsu_if #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32)) bus ();

  bram_lsu #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data one cycle after the address, including that cycle's write.
  logic [31:0] mem [0:65535];
  logic [31:0] ram_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    mem[bus.ram_address] <= merge(mem[bus.ram_address], bus.ram_data_out, bus.ram_write_enable);
    ram_rdata            <= merge(mem[bus.ram_address], bus.ram_data_out, bus.ram_write_enable);
  end

  assign bus.ram_data_in = ram_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, return in cycle T+1 with the request fields
  // scrambled so any late sampling shows up.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [17:0] a, input logic [31:0] d);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_address  = a;
    bus.req_data     = d;
    step();
    bus.req_valid    = 1'b0;
    bus.req_write    = ~w;
    bus.req_size     = ~sz;
    bus.req_unsigned = ~u;
    bus.req_address  = ~a;
    bus.req_data     = ~d;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [17:0] a, input logic [31:0] d, input logic split,
                      input logic [31:0] exp);
    send(w, sz, u, a, d);
    if (split) step();
    step();
    chk({tag, " vld"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, " dat"}, bus.rsp_data, exp);
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid    = 1'($urandom);
      bus.req_write    = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_address  = 18'($urandom);
      bus.req_data     = $urandom;
      step();
    end
    chk("rst ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst vld",   {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst rdat",  bus.rsp_data, 32'd0);
    chk("rst addr",  {16'd0, bus.ram_address}, 32'd0);
    chk("rst we",    {28'd0, bus.ram_write_enable}, 32'd0);
    chk("rst dout",  bus.ram_data_out, 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Aligned word store
    send(1'b1, 2'b10, 1'b0, 18'h00008, 32'hDEADBEEF);
    chk("st T1 addr",  {16'd0, bus.ram_address}, 32'd2);
    chk("st T1 we",    {28'd0, bus.ram_write_enable}, 32'hF);
    chk("st T1 dout",  bus.ram_data_out, 32'hDEADBEEF);
    chk("st T1 vld",   {31'd0, bus.rsp_valid}, 32'd0);
    chk("st T1 ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("st T2 vld",   {31'd0, bus.rsp_valid}, 32'd1);
    chk("st T2 rdat",  bus.rsp_data, 32'd0);
    chk("st T2 we",    {28'd0, bus.ram_write_enable}, 32'd0);
    chk("st T2 addr",  {16'd0, bus.ram_address}, 32'd2);
    step();
    chk("st T3 vld",   {31'd0, bus.rsp_valid}, 32'd0);
    chk("st T3 ready", {31'd0, bus.req_ready}, 32'd1);

    // Byte/half loads with sign handling
    xfer("pre0",   1'b1, 2'b10, 1'b0, 18'h00000, 32'h00008000, 1'b0, 32'd0);
    xfer("ldb s",  1'b0, 2'b00, 1'b0, 18'h00001, 32'd0, 1'b0, 32'hFFFFFF80);
    xfer("ldb u",  1'b0, 2'b00, 1'b1, 18'h00001, 32'd0, 1'b0, 32'h00000080);
    xfer("ldh s",  1'b0, 2'b01, 1'b0, 18'h00000, 32'd0, 1'b0, 32'hFFFF8000);

    // Byte store into lane 2
    send(1'b1, 2'b00, 1'b0, 18'h0000A, 32'h1234565A);
    chk("stb addr", {16'd0, bus.ram_address}, 32'd2);
    chk("stb we",   {28'd0, bus.ram_write_enable}, 32'h4);
    chk("stb dout", bus.ram_data_out, 32'h005A0000);
    step();
    chk("stb vld",  {31'd0, bus.rsp_valid}, 32'd1);
    step();
    xfer("ldw 8",  1'b0, 2'b10, 1'b0, 18'h00008, 32'd0, 1'b0, 32'hDE5ABEEF);
    xfer("ldb b",  1'b0, 2'b00, 1'b0, 18'h0000B, 32'd0, 1'b0, 32'hFFFFFFDE);
    xfer("pre1",   1'b1, 2'b10, 1'b0, 18'h00004, 32'h01020304, 1'b0, 32'd0);
    xfer("pre4",   1'b1, 2'b10, 1'b0, 18'h00010, 32'h12345678, 1'b0, 32'd0);

    // Reset in FIRST of a store: enables drop at once, nothing is written
    send(1'b1, 2'b10, 1'b0, 18'h00010, 32'hFFFFFFFF);
    chk("rf we pre", {28'd0, bus.ram_write_enable}, 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rf we",  {28'd0, bus.ram_write_enable}, 32'd0);
    chk("rf vld", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rf no vld", {31'd0, bus.rsp_valid}, 32'd0);
    end
    xfer("rf ldw", 1'b0, 2'b10, 1'b0, 18'h00010, 32'd0, 1'b0, 32'h12345678);

`ifdef BRAM_LSU_MISALIGNED_EN
    // Split store across words 0/1
    send(1'b1, 2'b10, 1'b0, 18'h00003, 32'h11223344);
    chk("sp T1 addr", {16'd0, bus.ram_address}, 32'd0);
    chk("sp T1 we",   {28'd0, bus.ram_write_enable}, 32'h8);
    chk("sp T1 dout", bus.ram_data_out, 32'h44000000);
    chk("sp T1 vld",  {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("sp T2 addr", {16'd0, bus.ram_address}, 32'd1);
    chk("sp T2 we",   {28'd0, bus.ram_write_enable}, 32'h7);
    chk("sp T2 dout", bus.ram_data_out, 32'h00112233);
    chk("sp T2 vld",  {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("sp T3 vld",  {31'd0, bus.rsp_valid}, 32'd1);
    chk("sp T3 we",   {28'd0, bus.ram_write_enable}, 32'd0);
    step();
    xfer("sp ldw1", 1'b0, 2'b10, 1'b0, 18'h00004, 32'd0, 1'b0, 32'h01112233);
    xfer("sp ldw0", 1'b0, 2'b10, 1'b0, 18'h00000, 32'd0, 1'b0, 32'h44008000);
    xfer("sp ldw3", 1'b0, 2'b10, 1'b0, 18'h00003, 32'd0, 1'b1, 32'h11223344);

    // Split load wrapping from the top word to word 0
    xfer("preF", 1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hAB000000, 1'b0, 32'd0);
    xfer("preZ", 1'b1, 2'b10, 1'b0, 18'h00000, 32'h000000CD, 1'b0, 32'd0);
    send(1'b0, 2'b01, 1'b1, 18'h3FFFF, 32'd0);
    chk("wr T1 addr", {16'd0, bus.ram_address}, 32'h0000FFFF);
    chk("wr T1 we",   {28'd0, bus.ram_write_enable}, 32'd0);
    step();
    chk("wr T2 addr", {16'd0, bus.ram_address}, 32'd0);
    chk("wr T2 we",   {28'd0, bus.ram_write_enable}, 32'd0);
    step();
    chk("wr T3 vld",  {31'd0, bus.rsp_valid}, 32'd1);
    chk("wr T3 rdat", bus.rsp_data, 32'h0000CDAB);
    step();
    xfer("wr ldh s", 1'b0, 2'b01, 1'b0, 18'h3FFFF, 32'd0, 1'b1, 32'hFFFFCDAB);

    // Reset in SECOND of a split store: only the FIRST half lands
    send(1'b1, 2'b10, 1'b0, 18'h00003, 32'hAABBCCDD);
    chk("rs T1 we",   {28'd0, bus.ram_write_enable}, 32'h8);
    chk("rs T1 dout", bus.ram_data_out, 32'hDD000000);
    step();
    chk("rs T2 we",   {28'd0, bus.ram_write_enable}, 32'h7);
    #1 rst_n = 1'b0;
    #1;
    chk("rs we",  {28'd0, bus.ram_write_enable}, 32'd0);
    chk("rs vld", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs no vld", {31'd0, bus.rsp_valid}, 32'd0);
    end
    send(1'b0, 2'b10, 1'b0, 18'h00004, 32'd0);
    chk("rs ld T1 vld", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("rs ld T2 vld", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rs ld T2 dat", bus.rsp_data, 32'h01112233);
    step();
    xfer("rs ldw0", 1'b0, 2'b10, 1'b0, 18'h00000, 32'd0, 1'b0, 32'hDD0000CD);
`else
    // Misaligned word store collapses to one aligned access
    send(1'b1, 2'b10, 1'b0, 18'h00003, 32'h11223344);
    chk("al T1 addr", {16'd0, bus.ram_address}, 32'd0);
    chk("al T1 we",   {28'd0, bus.ram_write_enable}, 32'hF);
    chk("al T1 dout", bus.ram_data_out, 32'h11223344);
    step();
    chk("al T2 vld",  {31'd0, bus.rsp_valid}, 32'd1);
    step();
    chk("al T3 vld",  {31'd0, bus.rsp_valid}, 32'd0);
    xfer("al ldh3", 1'b0, 2'b01, 1'b1, 18'h00003, 32'd0, 1'b0, 32'h00001122);
    xfer("al ldb3", 1'b0, 2'b00, 1'b1, 18'h00003, 32'd0, 1'b0, 32'h00000011);
    xfer("al ldw6", 1'b0, 2'b10, 1'b0, 18'h00006, 32'd0, 1'b0, 32'h01020304);
    send(1'b1, 2'b01, 1'b0, 18'h00007, 32'h0000BEEF);
    chk("al sth addr", {16'd0, bus.ram_address}, 32'd1);
    chk("al sth we",   {28'd0, bus.ram_write_enable}, 32'hC);
    chk("al sth dout", bus.ram_data_out, 32'hBEEF0000);
    step();
    chk("al sth vld",  {31'd0, bus.rsp_valid}, 32'd1);
    step();
    xfer("al ldw4", 1'b0, 2'b10, 1'b0, 18'h00004, 32'd0, 1'b0, 32'hBEEF0304);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
